// File: rtl/ej32_trace_buf.sv
// ej32_trace_buf: trace capture buffer for the EJ32 core.
// Records {p, code, phase, rp, sp, t} per traced event into a circular RAM,
// with free-run, start-on-trigger and stop-N-after-trigger sessions, plus
// an oldest-first indexed readout port.
module ej32_trace_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 17,
    parameter int unsigned DW    = 32,
    parameter int unsigned POST  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm,
    input  logic [1:0]                  mode,
    input  logic [7:0]                  trig_code,
    input  logic                        stop,
    input  logic                        ev_vld,
    input  logic [AW-1:0]               ev_p,
    input  logic [7:0]                  ev_code,
    input  logic [2:0]                  ev_phase,
    input  logic [4:0]                  ev_rp,
    input  logic [4:0]                  ev_sp,
    input  logic [DW-1:0]               ev_t,
    input  logic                        rd_en,
    input  logic [$clog2(DEPTH)-1:0]    rd_idx,
    output logic                        rd_vld,
    output logic [AW+21+DW-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic [2:0]                  state,
    output logic                        trig_hit
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned RW = AW + 21 + DW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          st;
    logic [1:0]      mode_q;
    logic [IW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   post_cnt;
    logic            hit;

    logic [RW-1:0]   mem [DEPTH];

    logic            trig_c;
    logic            wr_en_c;
    logic            full_c;
    logic [IW-1:0]   rd_addr_c;
    logic            rd_in_c;

    assign state    = st;
    assign count    = cnt;
    assign trig_hit = hit;

    // Write qualification and oldest-first read address; arm suppresses the write of a restart cycle.
    always_comb begin
        trig_c    = ev_vld && (ev_code == trig_code);
        wr_en_c   = 1'b0;
        if (!arm) begin
            case (st)
                S_ARMED:           wr_en_c = trig_c;
                S_CAPTURE, S_POST: wr_en_c = ev_vld;
                default:           wr_en_c = 1'b0;
            endcase
        end
        full_c    = (cnt == CW'(DEPTH));
        rd_addr_c = (full_c ? wr_ptr : IW'(0)) + rd_idx;
        rd_in_c   = ({1'b0, rd_idx} < cnt);
    end

    // Session FSM with write pointer, fill count, sticky trigger and post-trigger countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= S_IDLE;
            mode_q   <= 2'd0;
            wr_ptr   <= '0;
            cnt      <= '0;
            post_cnt <= '0;
            hit      <= 1'b0;
        end else if (arm) begin
            st       <= (mode == 2'd1) ? S_ARMED : S_CAPTURE;
            mode_q   <= mode;
            wr_ptr   <= '0;
            cnt      <= '0;
            post_cnt <= '0;
            hit      <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + IW'(1);
                if (!full_c) begin
                    cnt <= cnt + CW'(1);
                end
            end
            case (st)
                S_ARMED: begin
                    if (trig_c) begin
                        hit <= 1'b1;
                        st  <= stop ? S_DONE : S_CAPTURE;
                    end else if (stop) begin
                        st <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    if ((mode_q == 2'd2) && trig_c) begin
                        hit      <= 1'b1;
                        post_cnt <= IW'(POST);
                        st       <= stop ? S_DONE : S_POST;
                    end else if (stop) begin
                        st <= S_DONE;
                    end
                end
                S_POST: begin
                    if (ev_vld) begin
                        post_cnt <= post_cnt - IW'(1);
                        if ((post_cnt == IW'(1)) || stop) begin
                            st <= S_DONE;
                        end
                    end else if (stop) begin
                        st <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Trace RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= {ev_p, ev_code, ev_phase, ev_rp, ev_sp, ev_t};
        end
    end

    // Registered readout; out-of-range index returns zero, same-entry write yields old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en && rd_in_c) begin
                rd_data <= mem[rd_addr_c];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ej32_trace_buf.sv
// tb_ej32_trace_buf: scoreboard bench for the trace buffer.
module tb_ej32_trace_buf;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 32;
    localparam int unsigned POST  = 4;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned RW    = AW + 21 + DW;

    typedef logic [RW-1:0] rec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            arm = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [7:0]      trig_code = 8'hB6;
    logic            stop = 1'b0;
    logic            ev_vld = 1'b0;
    logic [AW-1:0]   ev_p = '0;
    logic [7:0]      ev_code = '0;
    logic [2:0]      ev_phase = '0;
    logic [4:0]      ev_rp = '0;
    logic [4:0]      ev_sp = '0;
    logic [DW-1:0]   ev_t = '0;
    logic            rd_en = 1'b0;
    logic [IW-1:0]   rd_idx = '0;
    logic            rd_vld;
    logic [RW-1:0]   rd_data;
    logic [IW:0]     count;
    logic [2:0]      state;
    logic            trig_hit;

    rec_t log_q[$];
    rec_t sb_q[$];
    logic rd_pend = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    ej32_trace_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .POST(POST)) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode), .trig_code(trig_code),
        .stop(stop), .ev_vld(ev_vld), .ev_p(ev_p), .ev_code(ev_code),
        .ev_phase(ev_phase), .ev_rp(ev_rp), .ev_sp(ev_sp), .ev_t(ev_t),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_vld(rd_vld), .rd_data(rd_data),
        .count(count), .state(state), .trig_hit(trig_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic [AW-1:0] p, input logic [7:0] code);
        logic [2:0]    ph = p[2:0];
        logic [4:0]    rp = p[4:0] ^ 5'h1f;
        logic [4:0]    sp = p[4:0] + 5'd3;
        logic [DW-1:0] t  = DW'({p, ~p});
        return {p, code, ph, rp, sp, t};
    endfunction

    // Expected read: oldest-first over everything written this session.
    function automatic rec_t expect_rd(input int idx);
        int n    = log_q.size();
        int held = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        int base = (n > int'(DEPTH)) ? n - int'(DEPTH) : 0;
        if (idx < held) return log_q[base + idx];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus: optional event, stop and read request.
    task automatic step(input bit v, input logic [AW-1:0] p, input logic [7:0] code,
                        input bit wr, input bit st, input bit r, input int ri);
        rec_t x = mk(p, code);
        ev_vld = v;
        {ev_p, ev_code, ev_phase, ev_rp, ev_sp, ev_t} = x;
        stop   = st;
        rd_en  = r;
        rd_idx = IW'(ri);
        if (r) sb_q.push_back(expect_rd(ri));
        if (v && wr) log_q.push_back(x);
        tick();
        ev_vld = 1'b0;
        stop   = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic ev(input int p, input logic [7:0] code, input bit wr);
        step(1'b1, AW'(p), code, wr, 1'b0, 1'b0, 0);
    endtask

    task automatic rd(input int i);
        step(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1, i);
    endtask

    task automatic do_arm(input logic [1:0] m);
        mode = m;
        arm  = 1'b1;
        log_q.delete();
        tick();
        arm = 1'b0;
    endtask

    always @(posedge clk) rd_pend <= rd_en;

    // Scoreboard drain: each valid read pops one expected record.
    always @(negedge clk) begin
        if (rst && (rd_pend || rd_vld)) begin
            check("rd_vld", 128'(rd_vld), 128'(rd_pend));
            if (rd_pend) begin
                if (sb_q.size() == 0) check("sb_underflow", 128'(1), 128'(0));
                else check("rd_data", 128'(rd_data), 128'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_state", 128'(state), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_trig", 128'(trig_hit), 128'(0));
        check("rst_rd_vld", 128'(rd_vld), 128'(0));
        check("rst_rd_data", 128'(rd_data), 128'(0));
        tick();
        rst = 1'b1;
        tick();

        // Free-run, 10 events, stop
        do_arm(2'd0);
        check("fr_state", 128'(state), 128'(2));
        for (int i = 0; i < 10; i++) ev(32'h100 + i, 8'h20, 1'b1);
        step(1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        check("fr_done", 128'(state), 128'(4));
        check("fr_count", 128'(count), 128'(10));
        rd(0);
        rd(9);
        rd(5);
        rd(20);
        ev(32'h200, 8'h20, 1'b0);
        check("done_ignore", 128'(count), 128'(10));

        // Wrap past DEPTH, simultaneous read/write of the oldest entry, stop-cycle write
        do_arm(2'd0);
        for (int i = 0; i < 70; i++) ev(i, 8'h30, 1'b1);
        check("wrap_count", 128'(count), 128'(DEPTH));
        rd(0);
        rd(63);
        rd(30);
        step(1'b1, AW'(70), 8'h31, 1'b1, 1'b0, 1'b1, 0);
        step(1'b1, AW'(71), 8'h32, 1'b1, 1'b1, 1'b0, 0);
        check("wrap_done", 128'(state), 128'(4));
        check("wrap_count2", 128'(count), 128'(DEPTH));
        rd(63);
        rd(0);

        // Start-on-trigger
        do_arm(2'd1);
        check("arm1_state", 128'(state), 128'(1));
        ev(1, 8'h10, 1'b0);
        ev(2, 8'h10, 1'b0);
        check("arm1_cnt0", 128'(count), 128'(0));
        ev(3, 8'hB6, 1'b1);
        check("arm1_cap", 128'(state), 128'(2));
        ev(4, 8'h11, 1'b1);
        check("arm1_count", 128'(count), 128'(2));
        check("arm1_trig", 128'(trig_hit), 128'(1));
        rd(0);
        rd(1);

        // Stop-POST-after-trigger
        do_arm(2'd2);
        check("m2_trig0", 128'(trig_hit), 128'(0));
        for (int i = 1; i <= 4; i++) ev(i, 8'h10, 1'b1);
        ev(5, 8'hB6, 1'b1);
        check("m2_post", 128'(state), 128'(3));
        check("m2_trig", 128'(trig_hit), 128'(1));
        for (int i = 6; i <= 8; i++) ev(i, 8'hB6, 1'b1);
        check("m2_still_post", 128'(state), 128'(3));
        ev(9, 8'h10, 1'b1);
        check("m2_done", 128'(state), 128'(4));
        for (int i = 10; i <= 12; i++) ev(i, 8'h10, 1'b0);
        check("m2_count", 128'(count), 128'(9));
        rd(8);
        rd(4);

        // Reserved mode acts as free-run; arm beats stop in the same cycle
        do_arm(2'd3);
        check("m3_state", 128'(state), 128'(2));
        ev(1, 8'h10, 1'b1);
        ev(2, 8'h10, 1'b1);
        mode   = 2'd0;
        arm    = 1'b1;
        stop   = 1'b1;
        ev_vld = 1'b1;
        log_q.delete();
        tick();
        arm = 1'b0; stop = 1'b0; ev_vld = 1'b0;
        check("armstop_state", 128'(state), 128'(2));
        check("armstop_count", 128'(count), 128'(0));

        // Reset mid-capture is immediate and aborts the session
        ev(7, 8'hB6, 1'b1);
        ev(8, 8'h10, 1'b1);
        rst = 1'b0;
        #2;
        check("arst_state", 128'(state), 128'(0));
        check("arst_count", 128'(count), 128'(0));
        tick();
        rst = 1'b1;
        log_q.delete();
        ev(9, 8'h10, 1'b0);
        ev(10, 8'h10, 1'b0);
        check("post_rst_state", 128'(state), 128'(0));
        check("post_rst_count", 128'(count), 128'(0));
        rd(0);

        repeat (3) tick();
        check("sb_drain", 128'(sb_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ej32_trace_buf.md
EJ32_TRACE_BUF -- requirements
Module: ej32_trace_buf

Parameters
REQ-001 DEPTH, 64, trace buffer entries; power of two, 4..1024.
REQ-002 AW, 17, program address width (p).
REQ-003 DW, 32, top-of-stack data width (t).
REQ-004 POST, 16, cycles captured after trigger in mode 2; 1..DEPTH-1.

Interface
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 arm  in  1  one-cycle pulse; starts a capture session.
REQ-008 mode  in  2  0=free-run, 1=start-on-trigger, 2=stop-POST-after-trigger, 3=reserved (acts as 0).
REQ-009 trig_code  in  8  opcode that fires the trigger.
REQ-010 stop  in  1  one-cycle pulse; ends capture.
REQ-011 ev_vld  in  1  trace event valid this cycle.
REQ-012 ev_p / ev_code / ev_phase / ev_rp / ev_sp / ev_t  in  AW/8/3/5/5/DW  event fields.
REQ-013 rd_en  in  1  readout request.
REQ-014 rd_idx  in  log2(DEPTH)  entry index, 0 = oldest captured.
REQ-015 rd_vld  out  1  rd_data valid.
REQ-016 rd_data  out  AW+21+DW  {p,code,phase,rp,sp,t}, p in MSBs.
REQ-017 count  out  log2(DEPTH)+1  entries held, saturates at DEPTH.
REQ-018 state  out  3  FSM state encoding below.
REQ-019 trig_hit  out  1  sticky; trigger fired this session.

Function
REQ-020 FSM states: IDLE=0, ARMED=1, CAPTURE=2, POST=3, DONE=4.
REQ-021 IDLE/DONE + arm: mode 1 -> ARMED; else -> CAPTURE; wr_ptr, count, trig_hit, post counter cleared same edge.
REQ-022 ARMED: event with ev_code==trig_code -> written as entry 0, trig_hit=1, -> CAPTURE.
REQ-023 CAPTURE: every ev_vld cycle writes one entry at wr_ptr; wr_ptr wraps modulo DEPTH; count +1 until DEPTH, then holds.
REQ-024 CAPTURE mode 2: first ev_code==trig_code sets trig_hit, writes the event, loads post counter=POST, -> POST.
REQ-025 POST: each written event decrements counter; write that makes it 0 -> DONE.
REQ-026 stop in ARMED/CAPTURE/POST -> DONE next edge; event in the stop cycle is still written (except ARMED without a trigger match).
REQ-027 arm in ARMED/CAPTURE/POST restarts session as REQ-021; arm and stop same cycle: arm wins.
REQ-028 No writes in IDLE/DONE; ev_vld ignored.
REQ-029 Readout in any state: physical addr = (count<DEPTH ? 0 : wr_ptr) + rd_idx mod DEPTH.
REQ-030 rd_vld and rd_data registered: 1-cycle latency after rd_en; rd_vld low when rd_en low.
REQ-031 rd_idx >= count: rd_vld=1, rd_data=0.
REQ-032 Simultaneous write and read of same physical entry: read returns old content.
REQ-033 Storage is single write port, single read port RAM; no reset of array contents required.

Reset
REQ-034 rst low: state=IDLE, count=0, wr_ptr=0, trig_hit=0, rd_vld=0, rd_data=0, post counter=0, immediately.
REQ-035 rst asserted mid-capture aborts session; after release, a new arm is needed.

Verification
REQ-036 mode 0, arm, 10 events p=0x100..0x109, stop -> DONE, count=10, rd_idx 0 gives p=0x100, rd_idx 9 gives p=0x109.
REQ-037 DEPTH=64, mode 0, 70 events p=0..69 -> count=64, rd_idx 0 gives p=6, rd_idx 63 gives p=69 (wrap).
REQ-038 mode 1, trig_code=0xB6, events code 0x10,0x10,0xB6,0x11 -> entry 0 code 0xB6, count=2, trig_hit=1.
REQ-039 mode 2, POST=4, trigger at 5th event, continuous events -> DONE after 9 writes, count=9, later events ignored.
REQ-040 rd_idx=20 with count=10 -> one cycle later rd_vld=1, rd_data=0; rst low during CAPTURE -> state=0, count=0 same cycle.
